// File: rtl/time_set_controller.sv
// time_set_controller: running clock time plus button-driven set mode with per-field blink mask
// Ports:
//   clk_src    clock; rst synchronous active-high reset
//   tick_1hz   one-cycle pulse per second, advances time in RUN and the set-mode timeout
//   btn_mode   advances RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN
//   btn_inc    increments the edited field (no carry) in set mode
//   sec_data, min_data, hour_data   zero-extended time fields
//   mode       00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC
//   blink_mask bit2 hour, bit1 min, bit0 sec; 1 blanks the field
// Define TIME_SET_BLINK_EN to build the blink counter; otherwise blink_mask is 000.
module time_set_controller #(
  parameter int WIDTH     = 32,
  parameter int BLINK_DIV = 25_000_000,
  parameter int TIMEOUT   = 10
) (
  input  logic             clk_src,
  input  logic             rst,
  input  logic             tick_1hz,
  input  logic             btn_mode,
  input  logic             btn_inc,
  output logic [WIDTH-1:0] sec_data,
  output logic [WIDTH-1:0] min_data,
  output logic [WIDTH-1:0] hour_data,
  output logic [1:0]       mode,
  output logic [2:0]       blink_mask
);
  typedef enum logic [1:0] {RUN = 2'b00, SET_HOUR = 2'b01, SET_MIN = 2'b10, SET_SEC = 2'b11} state_t;
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t        r_mode, w_mode_next;
  logic [4:0]    r_hour, w_hour_next, w_hour_inc;
  logic [5:0]    r_min, w_min_next, w_min_inc;
  logic [5:0]    r_sec, w_sec_next, w_sec_inc;
  logic [TW-1:0] r_to, w_to_next;
  logic [2:0]    r_blink_mask, w_mask_next;
  logic          w_set, w_inc, w_expire, w_run_tick;
  assign w_set      = r_mode != RUN;
  // a simultaneous mode press swallows the increment
  assign w_inc      = w_set && btn_inc && !btn_mode;
  // any button in the expiring cycle keeps set mode alive
  assign w_expire   = w_set && tick_1hz && !btn_mode && !btn_inc && r_to == TW'(TIMEOUT - 1);
  assign w_run_tick = !w_set && tick_1hz;
  assign w_sec_inc  = (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
  assign w_min_inc  = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
  assign w_hour_inc = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
  assign w_sec_next  = (w_run_tick || (w_inc && r_mode == SET_SEC)) ? w_sec_inc : r_sec;
  assign w_min_next  = ((w_run_tick && r_sec == 6'd59) || (w_inc && r_mode == SET_MIN)) ? w_min_inc : r_min;
  assign w_hour_next = ((w_run_tick && r_sec == 6'd59 && r_min == 6'd59) || (w_inc && r_mode == SET_HOUR)) ? w_hour_inc : r_hour;
  assign w_to_next = (!w_set || btn_mode || btn_inc || w_expire) ? '0 : tick_1hz ? r_to + TW'(1) : r_to;
  always_comb begin
    w_mode_next = r_mode;
    if (btn_mode)
      w_mode_next = (r_mode == RUN) ? SET_HOUR : (r_mode == SET_HOUR) ? SET_MIN : (r_mode == SET_MIN) ? SET_SEC : RUN;
    else if (w_expire)
      w_mode_next = RUN;
  end
  always_ff @(posedge clk_src) begin
    if (rst) r_mode <= RUN;
    else r_mode <= w_mode_next;
  end
`ifdef TIME_SET_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] r_blink_cnt;
  logic          r_phase, w_phase_next, w_wrap, w_mode_chg;
  assign w_mode_chg   = w_mode_next != r_mode;
  assign w_wrap       = r_blink_cnt == BW'(BLINK_DIV - 1);
  // restart visible on every mode change
  assign w_phase_next = w_mode_chg ? 1'b0 : r_phase ^ w_wrap;
  assign w_mask_next  = {3{w_phase_next}} &
                        ((w_mode_next == SET_HOUR) ? 3'b100 : (w_mode_next == SET_MIN) ? 3'b010 :
                         (w_mode_next == SET_SEC) ? 3'b001 : 3'b000);
  always_ff @(posedge clk_src) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else begin
      r_blink_cnt <= (w_mode_chg || w_wrap) ? '0 : r_blink_cnt + BW'(1);
      r_phase     <= w_phase_next;
    end
  end
`else
  logic w_unused_blink;
  assign w_unused_blink = ^BLINK_DIV;
  assign w_mask_next    = 3'b000;
`endif
  always_ff @(posedge clk_src) begin
    if (rst) begin
      r_hour       <= '0;
      r_min        <= '0;
      r_sec        <= '0;
      r_to         <= '0;
      r_blink_mask <= '0;
    end else begin
      r_hour       <= w_hour_next;
      r_min        <= w_min_next;
      r_sec        <= w_sec_next;
      r_to         <= w_to_next;
      r_blink_mask <= w_mask_next;
    end
  end
  assign sec_data   = WIDTH'(r_sec);
  assign min_data   = WIDTH'(r_min);
  assign hour_data  = WIDTH'(r_hour);
  assign mode       = r_mode;
  assign blink_mask = r_blink_mask;
endmodule

// File: tb/tb_time_set_controller.sv
// tb_time_set_controller: directed and randomized checks of time_set_controller against a time-of-day model
module tb_time_set_controller;
  localparam int BD = 4;
  localparam int TO = 10;
  logic        clk_src = 1'b0;
  logic        rst = 1'b1, tick_1hz = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [31:0] sec_data, min_data, hour_data;
  logic [1:0]  mode;
  logic [2:0]  blink_mask;
  int checks = 0, errors = 0;
  int m_h, m_m, m_s, m_mode, m_to, m_since;
  time_set_controller #(.WIDTH(32), .BLINK_DIV(BD), .TIMEOUT(TO)) dut (
    .clk_src(clk_src), .rst(rst), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec_data(sec_data), .min_data(min_data), .hour_data(hour_data), .mode(mode), .blink_mask(blink_mask)
  );
  always #5 clk_src = ~clk_src;
  function automatic logic [2:0] exp_mask();
`ifdef TIME_SET_BLINK_EN
    if (m_mode == 0 || ((m_since / BD) % 2) == 0) return 3'b000;
    return 3'b001 << (3 - m_mode);
`else
    return 3'b000;
`endif
  endfunction
  function automatic logic [2:0] blink_at(input int k, input logic [2:0] sel);
`ifdef TIME_SET_BLINK_EN
    return (((k / BD) % 2) == 1) ? sel : 3'b000;
`else
    return 3'b000;
`endif
  endfunction
  task automatic model(input logic r, input logic tk, input logic bm, input logic bi);
    int total, nm;
    bit ex;
    if (r) begin
      m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_to = 0; m_since = 0;
      return;
    end
    ex = 0;
    if (m_mode == 0 && tk) begin
      total = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
      m_h = total / 3600; m_m = (total / 60) % 60; m_s = total % 60;
    end
    if (m_mode != 0 && bi && !bm) begin
      if (m_mode == 1) m_h = (m_h + 1) % 24;
      else if (m_mode == 2) m_m = (m_m + 1) % 60;
      else m_s = (m_s + 1) % 60;
    end
    if (m_mode != 0) begin
      if (bm || bi) m_to = 0;
      else if (tk) begin
        m_to++;
        if (m_to == TO) begin m_to = 0; ex = 1; end
      end
    end
    nm = bm ? (m_mode + 1) % 4 : ex ? 0 : m_mode;
    m_since = (nm != m_mode) ? 0 : m_since + 1;
    m_mode = nm;
  endtask
  task automatic cycle(input logic r, input logic tk, input logic bm, input logic bi);
    rst = r; tick_1hz = tk; btn_mode = bm; btn_inc = bi;
    @(posedge clk_src);
    model(r, tk, bm, bi);
    #1;
    rst = 0; tick_1hz = 0; btn_mode = 0; btn_inc = 0;
  endtask
  task automatic test_reset();
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    checks++; if (sec_data !== 32'd0) begin errors++; $display("FAIL reset_sec got %0d want 0", sec_data); end
    checks++; if (min_data !== 32'd0) begin errors++; $display("FAIL reset_min got %0d want 0", min_data); end
    checks++; if (hour_data !== 32'd0) begin errors++; $display("FAIL reset_hour got %0d want 0", hour_data); end
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode got %0d want 0", mode); end
    checks++; if (blink_mask !== 3'b000) begin errors++; $display("FAIL reset_mask got %b want 000", blink_mask); end
  endtask
  task automatic test_rollover();
    cycle(0, 0, 1, 0);
    repeat (23) cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 0);
    repeat (59) cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 0);
    repeat (58) cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 0);
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL roll_mode got %0d want 0", mode); end
    checks++; if ({hour_data[7:0], min_data[7:0], sec_data[7:0]} !== {8'd23, 8'd59, 8'd58})
      begin errors++; $display("FAIL roll_set got %0d:%0d:%0d want 23:59:58", hour_data, min_data, sec_data); end
    cycle(0, 1, 0, 0);
    checks++; if ({hour_data[7:0], min_data[7:0], sec_data[7:0]} !== {8'd23, 8'd59, 8'd59})
      begin errors++; $display("FAIL roll_tick1 got %0d:%0d:%0d want 23:59:59", hour_data, min_data, sec_data); end
    cycle(0, 1, 0, 0);
    checks++; if ({hour_data, min_data, sec_data} !== 96'd0)
      begin errors++; $display("FAIL roll_tick2 got %0d:%0d:%0d want 0:0:0", hour_data, min_data, sec_data); end
  endtask
  task automatic test_set_wrap();
    repeat (3) cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 0);
    repeat ((22 - m_h + 24) % 24) cycle(0, 0, 0, 1);
    repeat (3) cycle(0, 0, 1, 0);
    checks++; if (hour_data !== 32'd22 || mode !== 2'd0) begin errors++; $display("FAIL wrap_setup got h=%0d mode=%0d want h=22 mode=0", hour_data, mode); end
    cycle(0, 0, 1, 0);
    checks++; if (mode !== 2'd1) begin errors++; $display("FAIL wrap_mode got %0d want 1", mode); end
    cycle(0, 0, 0, 1);
    checks++; if (hour_data !== 32'd23) begin errors++; $display("FAIL wrap_inc1 got %0d want 23", hour_data); end
    cycle(0, 0, 0, 1);
    checks++; if (hour_data !== 32'd0) begin errors++; $display("FAIL wrap_inc2 got %0d want 0", hour_data); end
    cycle(0, 0, 0, 1);
    checks++; if (hour_data !== 32'd1) begin errors++; $display("FAIL wrap_inc3 got %0d want 1", hour_data); end
    checks++; if (min_data !== 32'd0 || sec_data !== 32'd3) begin errors++; $display("FAIL wrap_other got m=%0d s=%0d want m=0 s=3", min_data, sec_data); end
    repeat (3) begin cycle(0, 1, 0, 0); cycle(0, 0, 0, 0); end
    checks++; if (sec_data !== 32'd3 || mode !== 2'd1) begin errors++; $display("FAIL wrap_frozen got s=%0d mode=%0d want s=3 mode=1", sec_data, mode); end
  endtask
  task automatic test_simultaneous();
    cycle(0, 0, 1, 0);
    repeat ((5 - m_m + 60) % 60) cycle(0, 0, 0, 1);
    checks++; if (min_data !== 32'd5 || mode !== 2'd2) begin errors++; $display("FAIL simul_setup got m=%0d mode=%0d want m=5 mode=2", min_data, mode); end
    cycle(0, 0, 1, 1);
    checks++; if (mode !== 2'd3) begin errors++; $display("FAIL simul_mode got %0d want 3", mode); end
    checks++; if (min_data !== 32'd5) begin errors++; $display("FAIL simul_min got %0d want 5", min_data); end
  endtask
  task automatic test_timeout();
    for (int i = 1; i <= TO; i++) begin
      cycle(0, 1, 0, 0);
      if (i < TO) begin
        checks++; if (mode !== 2'd3) begin errors++; $display("FAIL timeout_hold tick %0d got mode %0d want 3", i, mode); end
      end
      repeat (2) cycle(0, 0, 0, 0);
      if (i == TO) begin
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL timeout_exit got mode %0d want 0", mode); end
      end
    end
    checks++; if (sec_data !== 32'd3) begin errors++; $display("FAIL timeout_kept got s=%0d want 3", sec_data); end
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    checks++; if (sec_data !== 32'd5) begin errors++; $display("FAIL timeout_run got s=%0d want 5", sec_data); end
  endtask
  task automatic test_back_to_back();
    cycle(0, 1, 1, 0);
    checks++; if (sec_data !== 32'd6 || mode !== 2'd1) begin errors++; $display("FAIL b2b_tickmode got s=%0d mode=%0d want s=6 mode=1", sec_data, mode); end
    repeat (TO - 1) cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 1);
    checks++; if (mode !== 2'd1 || hour_data !== 32'd2) begin errors++; $display("FAIL b2b_expire_inc got h=%0d mode=%0d want h=2 mode=1", hour_data, mode); end
    repeat (TO - 1) cycle(0, 1, 0, 0);
    checks++; if (mode !== 2'd1) begin errors++; $display("FAIL b2b_restart got mode %0d want 1", mode); end
    cycle(0, 1, 0, 0);
    checks++; if (mode !== 2'd0 || hour_data !== 32'd2 || sec_data !== 32'd6)
      begin errors++; $display("FAIL b2b_exit got h=%0d s=%0d mode=%0d want h=2 s=6 mode=0", hour_data, sec_data, mode); end
  endtask
  task automatic test_blink();
    cycle(0, 0, 1, 0);
    for (int k = 0; k < 4 * BD; k++) begin
      if (k == 0) cycle(0, 0, 1, 0); else cycle(0, 0, 0, 0);
      checks++; if (blink_mask !== blink_at(k, 3'b010)) begin errors++; $display("FAIL blink_min k=%0d got %b want %b", k, blink_mask, blink_at(k, 3'b010)); end
    end
    for (int k = 0; k < 2 * BD; k++) begin
      if (k == 0) cycle(0, 0, 1, 0); else cycle(0, 0, 0, 0);
      checks++; if (blink_mask !== blink_at(k, 3'b001)) begin errors++; $display("FAIL blink_sec k=%0d got %b want %b", k, blink_mask, blink_at(k, 3'b001)); end
    end
  endtask
  task automatic test_reset_mid();
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    repeat ((7 - m_h + 24) % 24) cycle(0, 0, 0, 1);
    checks++; if (hour_data !== 32'd7 || mode !== 2'd1) begin errors++; $display("FAIL rstmid_setup got h=%0d mode=%0d want h=7 mode=1", hour_data, mode); end
    cycle(1, 1, 1, 1);
    checks++; if ({hour_data, min_data, sec_data} !== 96'd0 || mode !== 2'd0 || blink_mask !== 3'b000)
      begin errors++; $display("FAIL rstmid got %0d:%0d:%0d mode=%0d mask=%b want 0:0:0 mode=0 mask=000", hour_data, min_data, sec_data, mode, blink_mask); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0);
      checks++;
      if (hour_data !== 32'(m_h) || min_data !== 32'(m_m) || sec_data !== 32'(m_s) || mode !== 2'(m_mode) || blink_mask !== exp_mask()) begin
        errors++;
        $display("FAIL random cyc %0d got %0d:%0d:%0d mode=%0d mask=%b want %0d:%0d:%0d mode=%0d mask=%b",
                 i, hour_data, min_data, sec_data, mode, blink_mask, m_h, m_m, m_s, m_mode, exp_mask());
      end
    end
  endtask
  initial begin
    test_reset();
    test_rollover();
    test_set_wrap();
    test_simultaneous();
    test_timeout();
    test_back_to_back();
    test_blink();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/time_set_controller.md
# time_set_controller

Sequences the clock time registers that feed `time_displayer`. It keeps hours, minutes and seconds running from a 1 Hz enable pulse, and runs a button-driven set-mode state machine (hour → minute → second → run). It also produces a per-field blink mask so the display stage can flash the field being edited. It sits between the button debouncers and 1 Hz divider on one side and `time_displayer` on the other.

## Interface
Parameters:
- `WIDTH`, 32: width of each time output bus; matches `time_displayer`.
- `BLINK_DIV`, 25_000_000: `clk_src` cycles per blink half-period.
- `TIMEOUT`, 10: `tick_1hz` pulses without a button press before set mode auto-exits.

Ports (one clock; reset is synchronous and active-high):
- `clk_src`  in  1: clock source.
- `rst`  in  1: synchronous, active-high reset.
- `tick_1hz`  in  1: one-cycle enable pulse, once per second.
- `btn_mode`  in  1: debounced one-cycle pulse; advances the mode.
- `btn_inc`  in  1: debounced one-cycle pulse; increments the edited field.
- `sec_data`  out  WIDTH: seconds, 0–59.
- `min_data`  out  WIDTH: minutes, 0–59.
- `hour_data`  out  WIDTH: hours, 0–23.
- `mode`  out  2: 00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC.
- `blink_mask`  out  3: bit2 hour, bit1 min, bit0 sec. 1 = blank the field this phase.

## Operation
- FSM transitions on `btn_mode`: RUN→SET_HOUR→SET_MIN→SET_SEC→RUN.
- RUN:
  - On `tick_1hz`, sec +1.
  - sec 59→0 carries min +1; min 59→0 carries hour +1; hour 23→0.
  - `btn_inc` is ignored.
- SET_x:
  - Time is frozen; `tick_1hz` does not advance time.
  - `btn_inc` increments only the edited field, with no carry: hour 23→0, min 59→0, sec 59→0.
- Timeout:
  - In any SET_x state, a counter counts `tick_1hz` pulses.
  - Any `btn_mode` or `btn_inc` pulse clears it.
  - When it reaches `TIMEOUT`, the FSM returns to RUN and the counter clears.
  - Edited values are kept.
- Simultaneous events:
  - `btn_mode` and `btn_inc` in the same cycle: the mode advance wins and the increment is dropped.
  - `btn_mode` and `tick_1hz` in RUN: the time advances and the FSM enters SET_HOUR in the same cycle.
  - A timeout-expiring tick and `btn_inc` in the same cycle: the increment is applied, the counter clears, and there is no exit.
- Blink:
  - A phase bit toggles every `BLINK_DIV` cycles.
  - `blink_mask` has the edited field's bit equal to the phase bit; all other bits are 0.
  - In RUN, `blink_mask` = 000.
  - The blink counter and phase clear on every mode change, so the field is always visible first.
- Width: internal fields are 5/6 bits, zero-extended to `WIDTH`. Values are always in range.

## Timing
- All outputs are registered. Every response appears on the `clk_src` edge after the input pulse (latency 1).
- Reset applied on any edge, including mid-edit:
  - `sec_data` = `min_data` = `hour_data` = 0.
  - `mode` = 00.
  - `blink_mask` = 000.
  - Blink and timeout counters = 0.
- Reset has priority over all other inputs in the same cycle.
- `btn_*` held high for N cycles counts as N events. Upstream guarantees one-cycle pulses.

## Configuration
- `TIME_SET_BLINK_EN` defined: blink counter and phase are present and behave as in Operation.
- Not defined: the blink logic is removed, `blink_mask` is constant 000, and `BLINK_DIV` is unused.

## Test plan
- Rollover: reset, then force 23:59:58 via set mode, return to RUN, apply 2 ticks → 23:59:59, then 00:00:00.
- Set-mode wrap: mode 1 press (SET_HOUR) from hour=22, 3×`btn_inc` → hour 23, 0, 1. Min and sec are unchanged. `tick_1hz` pulses during this leave sec unchanged.
- Simultaneous pulses: in SET_MIN with min=5, `btn_mode` and `btn_inc` in the same cycle → mode=11, min stays 5.
- Timeout: enter SET_SEC, then 10 ticks with no button → mode=00 one cycle after the 10th tick. Ticks 11 and onward increment sec.
- Blink (`TIME_SET_BLINK_EN` defined, `BLINK_DIV`=4): in SET_MIN, `blink_mask` = 000 for 4 cycles, then 010 for 4, repeating. After a `btn_mode`, it restarts at 000 with bit0 selected.
- Reset mid-edit: in SET_HOUR with hour=7, assert `rst` for 1 cycle → all outputs 0 and mode=00 on the next edge.
